array_bus_fifo: RTL and testbench
=================================

// Module: array_bus_fifo
// PURPOSE
//  Multi-channel, parametrised buffering stage for array-typed (unpacked) buses.
//  Gives each of NUM_CH independent lanes a valid/ready handshake and a DEPTH-entry FIFO.
//  Replaces fixed 2-lane, 1-stage register slices between array-port producers and consumers.
//  Lanes share only clock and reset; there is no cross-lane ordering.
// PARAMETERS
//  NUM_CH  2  number of independent lanes (>=1)
//  DATA_W  8  payload width per lane in bits (>=1)
//  DEPTH   4  FIFO entries per lane; power of two, >=2
// PORTS
//  clk        in   1                clock; all logic on posedge
//  rst_n      in   1                synchronous reset, active-low
//  in_data    in   [DATA_W-1:0] x NUM_CH   per-lane write payload (unpacked [0:NUM_CH-1])
//  in_valid   in   1 x NUM_CH             per-lane write request
//  in_ready   out  1 x NUM_CH             per-lane space available
//  out_data   out  [DATA_W-1:0] x NUM_CH   per-lane head-of-FIFO payload
//  out_valid  out  1 x NUM_CH             per-lane data available
//  out_ready  in   1 x NUM_CH             per-lane consumer accept
//  out_level  out  [$clog2(DEPTH+1)-1:0] x NUM_CH   occupancy; only with ARRAY_BUS_LEVEL_EN
// BEHAVIOUR
//  Clock and reset
//  - One clock (clk). Reset is synchronous, active-low (rst_n) and sampled on posedge clk.
//  - While rst_n=0, at each clock edge per lane: count=0, pointers=0, out_valid=0, out_data=0, in_ready=0.
//  - in_ready rises on the first posedge with rst_n=1.
//  - Reset mid-operation discards all buffered entries without producing output.
//  Handshake
//  - Push when in_valid & in_ready. Pop when out_valid & out_ready.
//  - in_ready = (count != DEPTH) & reset deasserted. It is not combinationally dependent on out_ready.
//  - out_valid = (count != 0), registered.
//  - out_data holds the head entry and stays stable while out_valid=1 and out_ready=0.
//  Latency
//  - Push at edge N into an empty lane: out_valid=1 and out_data=payload after edge N (visible cycle N+1).
//  - There is no combinational in->out path.
//  Count update
//  - Push only: +1. Pop only: -1. Push and pop in the same cycle: unchanged.
//  - Write and read pointers wrap from DEPTH-1 to 0 (modulo DEPTH).
//  Boundaries
//  - Full lane (count=DEPTH): in_ready=0, so in_valid is ignored. A pop in that cycle makes in_ready=1 next cycle.
//  - Empty lane: out_valid=0 and out_ready is ignored. A same-cycle push is not bypassed; it appears next cycle.
//  - in_data is don't-care when in_valid=0. out_data is don't-care when out_valid=0.
//  - Lanes are fully independent: stalling lane k never affects lane j.
// CONFIGURATION
//  Macro ARRAY_BUS_LEVEL_EN
//  - Defined: the out_level port exists and equals the registered per-lane count (0..DEPTH).
//    out_level resets to 0 and updates on the same edge as count.
//  - Undefined: the out_level port is absent. All other behaviour is identical.
// TESTING
//  1. Reset: hold rst_n=0 for 3 clks with in_valid=1 -> in_ready=0, out_valid=0, out_data=0 on all lanes; in_ready=1 one clk after release.
//  2. Latency: lane0 push 8'hA5 with out_ready=1 -> out_valid=1, out_data=8'hA5 exactly 1 clk later, popped next edge; lane1 out_valid stays 0.
//  3. Full: NUM_CH=2, DEPTH=4, out_ready=0, push 8'h01..8'h05 on lane1 -> in_ready=0 after 4th push; 5th dropped; drain yields 01,02,03,04 in order.
//  4. Wrap and simultaneous: DEPTH=4, continuous push and pop for 10 beats 8'h10..8'h19 -> in-order output, count constant, no bubbles after the first.
//  5. Mid-op reset: lane0 holds 3 entries, rst_n=0 for 1 clk -> out_valid=0 next cycle, no stale data after release; with ARRAY_BUS_LEVEL_EN, out_level=0.
//  6. Independence: stall lane0 (out_ready=0) while streaming 20 beats on lane1 -> lane1 throughput 1 beat/clk, lane0 contents unchanged.

Source files
------------

// File: rtl/array_bus_fifo.sv
// Multi-lane valid/ready FIFO stage for unpacked array buses: NUM_CH independent lanes, DEPTH entries each.
// Optional occupancy output out_level is compiled in when the macro ARRAY_BUS_LEVEL_EN is defined.
module array_bus_fifo #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data   [0:NUM_CH-1],
    input  logic              in_valid  [0:NUM_CH-1],
    output logic              in_ready  [0:NUM_CH-1],
    output logic [DATA_W-1:0] out_data  [0:NUM_CH-1],
    output logic              out_valid [0:NUM_CH-1],
    input  logic              out_ready [0:NUM_CH-1]
`ifdef ARRAY_BUS_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] out_level [0:NUM_CH-1]
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        logic [DATA_W-1:0] mem_r [0:DEPTH-1];
        logic [PW-1:0]     wr_ptr_r;
        logic [PW-1:0]     rd_ptr_r;
        logic [PW-1:0]     wr_ptr_s;
        logic [PW-1:0]     rd_ptr_s;
        logic [CW-1:0]     count_r;
        logic [CW-1:0]     count_s;
        logic [DATA_W-1:0] head_r;
        logic [DATA_W-1:0] head_s;
        logic              valid_r;
        logic              ready_r;
        logic              push_s;
        logic              pop_s;

        assign push_s = in_valid[g] & ready_r;
        assign pop_s  = out_ready[g] & valid_r;

        // Next occupancy and pointers from this cycle's handshakes.
        always_comb begin
            count_s  = count_r;
            wr_ptr_s = wr_ptr_r;
            rd_ptr_s = rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_ONE;
                2'b01:   count_s = count_r - CNT_ONE;
                default: count_s = count_r;
            endcase
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
        end

        // Next head word; a push landing in the slot that becomes the head is forwarded
        // into the output register (never straight to the port), so latency stays one clock.
        always_comb begin
            head_s = head_r;
            if (count_s == CNT_ZERO) begin
                head_s = head_r;
            end else if (push_s && (wr_ptr_r == rd_ptr_s)) begin
                head_s = in_data[g];
            end else begin
                head_s = mem_r[rd_ptr_s];
            end
        end

        // Lane state and registered handshake outputs.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count_r  <= '0;
                head_r   <= '0;
                valid_r  <= 1'b0;
                ready_r  <= 1'b0;
            end else begin
                wr_ptr_r <= wr_ptr_s;
                rd_ptr_r <= rd_ptr_s;
                count_r  <= count_s;
                head_r   <= head_s;
                valid_r  <= (count_s != CNT_ZERO);
                ready_r  <= (count_s != CNT_FULL);
            end
        end

        // Payload storage needs no reset; occupancy gates every read.
        always_ff @(posedge clk) begin
            if (rst_n && push_s) begin
                mem_r[wr_ptr_r] <= in_data[g];
            end
        end

        assign in_ready[g]  = ready_r;
        assign out_valid[g] = valid_r;
        assign out_data[g]  = head_r;
`ifdef ARRAY_BUS_LEVEL_EN
        assign out_level[g] = count_r;
`endif
    end

endmodule

// File: tb/tb_array_bus_fifo.sv
// Self-checking bench for array_bus_fifo: directed scenarios plus random traffic against a queue model.
module tb_array_bus_fifo;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int LW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_data   [0:NUM_CH-1];
    logic              in_valid  [0:NUM_CH-1];
    logic              in_ready  [0:NUM_CH-1];
    logic [DATA_W-1:0] out_data  [0:NUM_CH-1];
    logic              out_valid [0:NUM_CH-1];
    logic              out_ready [0:NUM_CH-1];
`ifdef ARRAY_BUS_LEVEL_EN
    logic [LW-1:0]     out_level [0:NUM_CH-1];
`endif

    array_bus_fifo #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ARRAY_BUS_LEVEL_EN
        ,
        .out_level (out_level)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: one queue of payloads per lane
    logic [DATA_W-1:0] q [NUM_CH][$];
    bit                m_rdy [NUM_CH];
    bit                m_rst;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int l = 0; l < NUM_CH; l++) begin
            check_eq($sformatf("in_ready[%0d]", l), 32'(in_ready[l]), 32'(m_rdy[l]));
            check_eq($sformatf("out_valid[%0d]", l), 32'(out_valid[l]), 32'(q[l].size() != 0));
            if (m_rst) begin
                check_eq($sformatf("rst_out_data[%0d]", l), 32'(out_data[l]), 32'h0);
            end else if (q[l].size() != 0) begin
                check_eq($sformatf("out_data[%0d]", l), 32'(out_data[l]), 32'(q[l][0]));
            end
`ifdef ARRAY_BUS_LEVEL_EN
            check_eq($sformatf("out_level[%0d]", l), 32'(out_level[l]), 32'(q[l].size()));
`endif
        end
    endtask

    // one clock: model the handshakes from the visible state, advance, then check at negedge
    task automatic tick();
        bit push [NUM_CH];
        bit pop  [NUM_CH];
        for (int l = 0; l < NUM_CH; l++) begin
            push[l] = in_valid[l] && m_rdy[l];
            pop[l]  = out_ready[l] && (q[l].size() != 0);
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int l = 0; l < NUM_CH; l++) begin
                q[l].delete();
                m_rdy[l] = 1'b0;
            end
            m_rst = 1'b1;
        end else begin
            for (int l = 0; l < NUM_CH; l++) begin
                if (pop[l]) void'(q[l].pop_front());
                if (push[l]) q[l].push_back(in_data[l]);
                m_rdy[l] = (q[l].size() != DEPTH);
            end
            m_rst = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        for (int l = 0; l < NUM_CH; l++) begin
            in_valid[l]  = 1'b0;
            in_data[l]   = 8'($urandom);
            out_ready[l] = 1'b0;
        end
    endtask

    int beats1;

    initial begin
        m_rst = 1'b1;
        for (int l = 0; l < NUM_CH; l++) m_rdy[l] = 1'b0;
        rst_n = 1'b0;
        idle_inputs();

        // reset with writes requested
        for (int l = 0; l < NUM_CH; l++) begin
            in_valid[l] = 1'b1;
            in_data[l]  = 8'hEE;
        end
        repeat (3) tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();

        // single-beat latency on lane0
        in_valid[0] = 1'b1; in_data[0] = 8'hA5; out_ready[0] = 1'b1;
        tick();
        check_eq("lat_valid", 32'(out_valid[0]), 32'h1);
        check_eq("lat_data", 32'(out_data[0]), 32'hA5);
        check_eq("lat_lane1_idle", 32'(out_valid[1]), 32'h0);
        in_valid[0] = 1'b0;
        tick();
        check_eq("lat_popped", 32'(out_valid[0]), 32'h0);
        idle_inputs();

        // fill lane1 past capacity, then drain
        for (int i = 1; i <= 5; i++) begin
            in_valid[1] = 1'b1; in_data[1] = 8'(i);
            tick();
        end
        check_eq("full_ready", 32'(in_ready[1]), 32'h0);
        in_valid[1] = 1'b0; out_ready[1] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_eq("drain_order", 32'(out_data[1]), 32'(i));
            tick();
        end
        check_eq("drain_empty", 32'(out_valid[1]), 32'h0);
        idle_inputs();

        // continuous push/pop across pointer wrap on lane0
        out_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'b1; in_data[0] = 8'(8'h10 + i);
            tick();
            check_eq("stream_nobubble", 32'(out_valid[0]), 32'h1);
            check_eq("stream_data", 32'(out_data[0]), 32'(8'h10 + i));
        end
        in_valid[0] = 1'b0;
        tick();
        idle_inputs();

        // mid-operation reset with three entries held
        for (int i = 0; i < 3; i++) begin
            in_valid[0] = 1'b1; in_data[0] = 8'(8'h30 + i);
            tick();
        end
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        tick();
        check_eq("midrst_valid", 32'(out_valid[0]), 32'h0);
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        repeat (2) tick();
        check_eq("midrst_nostale", 32'(out_valid[0]), 32'h0);
        idle_inputs();

        // lane0 stalled with content while lane1 streams
        in_valid[0] = 1'b1; in_data[0] = 8'h77;
        tick();
        in_valid[0] = 1'b1; in_data[0] = 8'h78;
        tick();
        in_valid[0] = 1'b0;
        out_ready[1] = 1'b1;
        beats1 = 0;
        for (int i = 0; i < 21; i++) begin
            in_valid[1] = (i < 20); in_data[1] = 8'(8'h40 + i);
            tick();
            if (out_valid[1] && out_ready[1]) beats1++;
            check_eq("indep_lane0_head", 32'(out_data[0]), 32'h77);
        end
        check_eq("indep_lane1_beats", 32'(beats1), 32'd20);
        idle_inputs();
        tick();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int l = 0; l < NUM_CH; l++) begin
                in_valid[l]  = ($urandom_range(0, 99) < 60);
                in_data[l]   = 8'($urandom);
                out_ready[l] = ($urandom_range(0, 99) < (l == 0 ? 40 : 70));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
